// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave between the inst and data
// masters. An in-order tag FIFO routes each response back to its issuer.
// Ports: aclk/aresetn, inst_* and data_* master bundles, m_* slave bundle,
// err_orphan sticky flag. Optional ARB_ROUND_ROBIN_EN: round-robin pick
// between simultaneous requesters instead of fixed data-over-inst priority.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        err_orphan
);

  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_grant;
  logic            w_grant_nxt;
  logic            r_tag [MAX_OUTSTANDING];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_count;
  logic            r_orphan;

  logic            w_full;
  logic            w_empty;
  logic            w_sel;
  logic            w_sel_req;
  logic            w_push;
  logic            w_pop;
  logic            w_head;

`ifdef ARB_ROUND_ROBIN_EN
  logic            r_rr;
`endif

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    if (int'(p) == MAX_OUTSTANDING - 1)
      return '0;
    return p + PW'(1);
  endfunction

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // HOLD locks the choice to the grant register
  always_comb begin
    w_sel = r_grant;
    if (r_state == ST_IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (inst_req & data_req)
        w_sel = r_rr;
      else
        w_sel = data_req ? M_DATA : M_INST;
`else
      w_sel = data_req ? M_DATA : M_INST;
`endif
    end
  end

  assign w_sel_req = w_sel ? data_req : inst_req;
  assign m_req     = aresetn & w_sel_req & ~w_full;
  assign m_wr      = w_sel ? data_wr    : inst_wr;
  assign m_size    = w_sel ? data_size  : inst_size;
  assign m_addr    = w_sel ? data_addr  : inst_addr;
  assign m_wdata   = w_sel ? data_wdata : inst_wdata;

  assign w_push = m_req & m_addr_ok;
  assign w_pop  = aresetn & m_data_ok & ~w_empty;
  assign w_head = r_tag[r_rp];

  assign inst_addr_ok = w_push & (w_sel == M_INST);
  assign data_addr_ok = w_push & (w_sel == M_DATA);
  assign inst_data_ok = w_pop & (w_head == M_INST);
  assign data_data_ok = w_pop & (w_head == M_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_orphan   = r_orphan;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    unique case (r_state)
      ST_IDLE: begin
        if (m_req & ~m_addr_ok) begin
          w_state_nxt = ST_HOLD;
          w_grant_nxt = w_sel;
        end
      end
      ST_HOLD: begin
        // accepted, or master illegally withdrew
        if (w_push | ~w_sel_req)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_grant <= M_DATA;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        r_tag[i] <= M_INST;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wp] <= w_sel;
        r_wp        <= f_inc(r_wp);
      end
      if (w_pop)
        r_rp <= f_inc(r_rp);
      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (~w_push & w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_orphan <= 1'b0;
    else if (m_data_ok & w_empty)
      r_orphan <= 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_rr <= M_INST;
    else if (w_push)
      r_rr <= ~w_sel;
  end
`endif

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port between the instruction-fetch and data-access sram-like masters of the CPU core.
- Sits between the CPU and the sram-like-to-AXI bridge, so the bridge sees a single requester.
- Tracks outstanding accepted transactions in an in-order tag FIFO, so every data_ok and rdata returns to the master that issued the request.
- Holds each grant until its address is accepted.

Parameters:
- MAX_OUTSTANDING, 2, depth of the tag FIFO (transactions accepted but not yet answered); power of two, at least 1.

Ports:
- aclk  input  1  clock; all state changes on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- inst_req  input  1  instruction master request.
- inst_wr  input  1  instruction master write flag.
- inst_size  input  2  instruction master transfer size.
- inst_addr  input  32  instruction master address.
- inst_wdata  input  32  instruction master write data.
- inst_rdata  output  32  read data returned to the instruction master.
- inst_addr_ok  output  1  instruction request accepted.
- inst_data_ok  output  1  instruction response valid.
- data_req, data_wr, data_size, data_addr, data_wdata  inputs  1/1/2/32/32  data master request bundle, same meaning as the inst_* inputs.
- data_rdata  output  32  read data returned to the data master.
- data_addr_ok  output  1  data request accepted.
- data_data_ok  output  1  data response valid.
- m_req  output  1  request to the slave.
- m_wr  output  1  write flag to the slave.
- m_size  output  2  transfer size to the slave.
- m_addr  output  32  address to the slave.
- m_wdata  output  32  write data to the slave.
- m_rdata  input  32  read data from the slave.
- m_addr_ok  input  1  slave accepted the request.
- m_data_ok  input  1  slave response valid.
- err_orphan  output  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset (asynchronous, aresetn low):
  - FIFO empty; state IDLE; grant register = DATA; rr pointer = INST; err_orphan = 0.
  - m_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are all 0 while reset is held.
  - Responses arriving after reset, for requests issued before it, are handled as orphans.
- States:
  - IDLE: no grant is locked.
  - HOLD: a request has been driven and not yet accepted.
- full = (count == MAX_OUTSTANDING), taken from the registered count. A pop in the same cycle does not bypass full.
- IDLE behaviour:
  - sel is chosen combinationally among the active requests. Without the optional feature, data has fixed priority over inst.
  - m_req = (inst_req | data_req) & ~full.
  - The m_* bundle muxes the selected master's signals.
  - If m_req is high and m_addr_ok is high in the same cycle, the request is accepted in that cycle: push sel into the FIFO and stay in IDLE.
  - If m_req is high and m_addr_ok is low, latch sel into the grant register and go to HOLD.
- HOLD behaviour:
  - The m_* bundle follows the grant register only; the other master's request is ignored.
  - m_req = granted master's req & ~full.
  - On m_addr_ok: push the grant and return to IDLE.
  - If the granted master drops req (illegal), return to IDLE with no push.
- Address accept outputs: inst_addr_ok = m_addr_ok & m_req & (sel==INST); data_addr_ok is the same with DATA. sel means the grant register while in HOLD.
- Responses:
  - On m_data_ok with the FIFO non-empty: pop the head and pulse the head master's data_ok in the same cycle (zero latency).
  - inst_rdata and data_rdata both equal m_rdata directly.
- Same-cycle push and pop are allowed; count is unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- m_data_ok with the FIFO empty: no pop, no data_ok to either master, and err_orphan is set and stays 1 until reset.
- Ordering: responses are assumed to come back in accept order, and the FIFO routes them in that order.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined: if both masters request in IDLE, the master named by the rr pointer wins. On each accepted push, rr toggles to the master that did not win. A single requester always wins.
- When undefined: fixed data-over-inst priority, and the rr register is not built.

Test Plan:
- Single inst read at 0xBFC00000, with m_addr_ok the same cycle and m_data_ok 2 cycles later carrying 0x3C1D0010 -> inst_addr_ok pulses once; inst_data_ok pulses with inst_rdata=0x3C1D0010; data_data_ok stays 0.
- inst and data request together (data read at 0x80001000), feature off -> data accepted first, then inst; responses R1 and R2 go to data then inst respectively.
- m_addr_ok held low for 3 cycles while data_req rises during an inst HOLD -> m_addr stays the inst address all 3 cycles; the data request is served after the inst accept.
- Depth 2: two accepts with no response -> m_req forced 0 despite a pending req. One m_data_ok -> m_req reasserts the next cycle, not the same cycle.
- m_data_ok with nothing outstanding -> err_orphan=1 and stays 1; no data_ok pulses. Then assert aresetn=0 mid-HOLD -> all outputs 0 immediately, FIFO empty, err_orphan=0.
- ARB_ROUND_ROBIN_EN defined, both masters requesting continuously with instant addr_ok -> grants alternate inst, data, inst, data.
